// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with first-word-fall-through read data.
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_ERR_FLAGS_EN.
module sync_fifo #(
  parameter int B = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  output logic         empty,
  output logic         full,
  output logic [B-1:0] r_data,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  input  logic         wr,
`ifdef FIFO_ERR_FLAGS_EN
  output logic         overflow,
  output logic         underflow,
`endif
  output logic [W-1:0] w_ptr_succ,
  output logic [W-1:0] r_ptr_succ
);

  localparam int DEPTH = 2 ** W;

  logic [B-1:0] storage_r [DEPTH];
  logic [W-1:0] w_ptr_r;
  logic [W-1:0] r_ptr_r;
  logic         full_r;
  logic         empty_r;

  logic [W-1:0] w_ptr_succ_s;
  logic [W-1:0] r_ptr_succ_s;
  logic [W-1:0] w_ptr_next_s;
  logic [W-1:0] r_ptr_next_s;
  logic         full_next_s;
  logic         empty_next_s;
  logic         wr_en_s;

  assign w_ptr_succ_s = w_ptr_r + W'(1);
  assign r_ptr_succ_s = r_ptr_r + W'(1);
  // A write while full is still legal when a pop frees the head slot in the same cycle.
  assign wr_en_s      = wr & (~full_r | rd);

  assign empty      = empty_r;
  assign full       = full_r;
  assign r_data     = storage_r[r_ptr_r];
  assign w_ptr_succ = w_ptr_succ_s;
  assign r_ptr_succ = r_ptr_succ_s;

  // Next pointer and status decode from the {wr,rd} request pair.
  always_comb begin
    w_ptr_next_s = w_ptr_r;
    r_ptr_next_s = r_ptr_r;
    full_next_s  = full_r;
    empty_next_s = empty_r;
    case ({wr, rd})
      2'b01: begin
        if (!empty_r) begin
          r_ptr_next_s = r_ptr_succ_s;
          full_next_s  = 1'b0;
          empty_next_s = (r_ptr_succ_s == w_ptr_r);
        end else begin
          r_ptr_next_s = r_ptr_r;
        end
      end
      2'b10: begin
        if (!full_r) begin
          w_ptr_next_s = w_ptr_succ_s;
          empty_next_s = 1'b0;
          full_next_s  = (w_ptr_succ_s == r_ptr_r);
        end else begin
          w_ptr_next_s = w_ptr_r;
        end
      end
      2'b11: begin
        if (empty_r) begin
          w_ptr_next_s = w_ptr_succ_s;
          empty_next_s = 1'b0;
        end else begin
          w_ptr_next_s = w_ptr_succ_s;
          r_ptr_next_s = r_ptr_succ_s;
        end
      end
      default: begin
        w_ptr_next_s = w_ptr_r;
        r_ptr_next_s = r_ptr_r;
      end
    endcase
  end

  // Pointer, status and storage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_r <= '0;
      r_ptr_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        storage_r[i] <= '0;
      end
    end else begin
      w_ptr_r <= w_ptr_next_s;
      r_ptr_r <= r_ptr_next_s;
      full_r  <= full_next_s;
      empty_r <= empty_next_s;
      if (wr_en_s) begin
        storage_r[w_ptr_r] <= w_data;
      end
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  assign overflow  = overflow_r;
  assign underflow = underflow_r;

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr && full_r && !rd) begin
        overflow_r <= 1'b1;
      end
      if (rd && empty_r && !wr) begin
        underflow_r <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (B=8, W=3), default build.
module tb_sync_fifo;

  logic       clk;
  logic       reset;
  logic       empty;
  logic       full;
  logic [7:0] r_data;
  logic [7:0] w_data;
  logic       rd;
  logic       wr;
  logic [2:0] w_ptr_succ;
  logic [2:0] r_ptr_succ;

  int checks   = 0;
  int failures = 0;

  sync_fifo #(.B(8), .W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .empty      (empty),
    .full       (full),
    .r_data     (r_data),
    .w_data     (w_data),
    .rd         (rd),
    .wr         (wr),
    .w_ptr_succ (w_ptr_succ),
    .r_ptr_succ (r_ptr_succ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one request for a single rising edge; outputs are sampled at the next falling edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    wr     = w;
    rd     = r;
    w_data = d;
    @(negedge clk);
    wr     = 1'b0;
    rd     = 1'b0;
    w_data = 8'd0;
  endtask

  logic [7:0] drain_exp [8] = '{8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};

  initial begin
    wr = 1'b0; rd = 1'b0; w_data = 8'd0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_rdata", 32'(r_data), 32'd0);
    check_eq("rst_wsucc", 32'(w_ptr_succ), 32'd1);
    check_eq("rst_rsucc", 32'(r_ptr_succ), 32'd1);

    cycle(1'b1, 1'b0, 8'd10);
    check_eq("first_word_fall", 32'(r_data), 32'd10);
    cycle(1'b1, 1'b0, 8'd20);
    cycle(1'b1, 1'b0, 8'd30);
    cycle(1'b1, 1'b0, 8'd40);
    check_eq("fill4_rdata", 32'(r_data), 32'd10);
    check_eq("fill4_empty", 32'(empty), 32'd0);
    check_eq("fill4_full", 32'(full), 32'd0);
    check_eq("fill4_wsucc", 32'(w_ptr_succ), 32'd5);

    cycle(1'b0, 1'b1, 8'd0);
    check_eq("pop_rdata", 32'(r_data), 32'd20);
    check_eq("pop_rsucc", 32'(r_ptr_succ), 32'd2);

    cycle(1'b1, 1'b0, 8'd50);
    cycle(1'b1, 1'b0, 8'd60);
    cycle(1'b1, 1'b0, 8'd70);
    cycle(1'b1, 1'b0, 8'd80);
    check_eq("seven_not_full", 32'(full), 32'd0);
    cycle(1'b1, 1'b0, 8'd90);
    check_eq("wrap_full", 32'(full), 32'd1);
    check_eq("wrap_empty", 32'(empty), 32'd0);
    check_eq("wrap_wsucc", 32'(w_ptr_succ), 32'd2);

    cycle(1'b1, 1'b0, 8'd99);
    check_eq("ovf_full", 32'(full), 32'd1);
    check_eq("ovf_rdata", 32'(r_data), 32'd20);
    check_eq("ovf_wsucc", 32'(w_ptr_succ), 32'd2);

    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("drain_%0d", i), 32'(r_data), 32'(drain_exp[i]));
      cycle(1'b0, 1'b1, 8'd0);
      check_eq($sformatf("drain_full_%0d", i), 32'(full), 32'd0);
    end
    check_eq("drain_empty", 32'(empty), 32'd1);
    check_eq("drain_rsucc", 32'(r_ptr_succ), 32'd2);

    cycle(1'b0, 1'b1, 8'd0);
    check_eq("udf_rsucc", 32'(r_ptr_succ), 32'd2);
    check_eq("udf_wsucc", 32'(w_ptr_succ), 32'd2);
    check_eq("udf_empty", 32'(empty), 32'd1);

    cycle(1'b1, 1'b1, 8'd5);
    check_eq("rw_empty_rdata", 32'(r_data), 32'd5);
    check_eq("rw_empty_empty", 32'(empty), 32'd0);
    check_eq("rw_empty_rsucc", 32'(r_ptr_succ), 32'd2);
    check_eq("rw_empty_wsucc", 32'(w_ptr_succ), 32'd3);

    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b0, 8'(11 + i));
    end
    check_eq("refill_full", 32'(full), 32'd1);
    check_eq("refill_head", 32'(r_data), 32'd5);

    cycle(1'b1, 1'b1, 8'd100);
    check_eq("rw_full_full", 32'(full), 32'd1);
    check_eq("rw_full_rdata", 32'(r_data), 32'd11);
    check_eq("rw_full_rsucc", 32'(r_ptr_succ), 32'd3);
    check_eq("rw_full_wsucc", 32'(w_ptr_succ), 32'd3);

    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 8'd0);
    end
    check_eq("three_left_rdata", 32'(r_data), 32'd16);
    check_eq("three_left_full", 32'(full), 32'd0);
    check_eq("three_left_empty", 32'(empty), 32'd0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_empty", 32'(empty), 32'd1);
    check_eq("mid_rst_full", 32'(full), 32'd0);
    check_eq("mid_rst_rdata", 32'(r_data), 32'd0);
    check_eq("mid_rst_wsucc", 32'(w_ptr_succ), 32'd1);
    check_eq("mid_rst_rsucc", 32'(r_ptr_succ), 32'd1);

    cycle(1'b1, 1'b0, 8'd1);
    cycle(1'b1, 1'b0, 8'd2);
    cycle(1'b1, 1'b1, 8'd3);
    check_eq("rw_mid_rdata", 32'(r_data), 32'd2);
    check_eq("rw_mid_empty", 32'(empty), 32'd0);
    check_eq("rw_mid_wsucc", 32'(w_ptr_succ), 32'd4);
    check_eq("rw_mid_rsucc", 32'(r_ptr_succ), 32'd2);
    cycle(1'b0, 1'b1, 8'd0);
    check_eq("rw_mid_tail", 32'(r_data), 32'd3);
    cycle(1'b0, 1'b1, 8'd0);
    check_eq("rw_mid_drained", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock circular-buffer FIFO: 2**W words of B bits, held in a register file addressed by separate write and read pointers.
- Provides full/empty status and first-word-fall-through read data.
- Exposes the successor (pointer+1) values of both pointers for debug and adjacent logic.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
- B  8  data word width in bits
- W  3  address width; depth = 2**W words (8 by default)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- empty  output  1  high when the FIFO holds 0 words
- full  output  1  high when the FIFO holds 2**W words
- r_data  output  B  word at the head of the FIFO (combinational from storage[r_ptr])
- w_data  input  B  word to write
- rd  input  1  read (pop) request
- wr  input  1  write (push) request
- w_ptr_succ  output  W  write pointer + 1, modulo 2**W
- r_ptr_succ  output  W  read pointer + 1, modulo 2**W

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous and active-high and has priority over all other activity.
- Reset values:
  - w_ptr=0, r_ptr=0, so w_ptr_succ=1 and r_ptr_succ=1.
  - empty=1, full=0.
  - All storage words cleared to 0, so r_data=0.
- Internal state: w_ptr[W-1:0], r_ptr[W-1:0], full register, empty register, storage[0..2**W-1].
- Write-enable = wr & (~full | rd). On write-enable, storage[w_ptr] <= w_data.
- r_data = storage[r_ptr] at all times. No read latency: the head word is visible the cycle after it is written. Popping advances to the next word immediately after the edge.
- Per-cycle operations, decided on {wr,rd}:
  - 00: no change.
  - 01 (read): if ~empty: r_ptr<=r_ptr+1, full<=0, empty<=(r_ptr+1==w_ptr). If empty: ignored, no state change (underflow).
  - 10 (write): if ~full: write storage, w_ptr<=w_ptr+1, empty<=0, full<=(w_ptr+1==r_ptr). If full: ignored, storage unchanged (overflow).
  - 11 while empty: write only. w_ptr advances, empty<=0, read ignored.
  - 11 while full: read and write both happen. Both pointers advance, full stays 1.
  - 11 otherwise: both pointers advance, full and empty unchanged.
- Pointers wrap from 2**W-1 to 0 naturally via W-bit arithmetic. w_ptr_succ and r_ptr_succ wrap identically.
- full and empty are never both 1.
- Inputs are sampled at the rising edge; the driver changes them on the falling edge.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds outputs overflow (1) and underflow (1), both sticky, cleared only by reset.
  - overflow sets when wr=1, full=1 and rd=0 at a clock edge.
  - underflow sets when rd=1, empty=1 and wr=0 at a clock edge.
- Not defined: ports and logic are absent; the port list is exactly as above.

Test Plan:
- Reset: assert reset for one cycle -> empty=1, full=0, r_data=0, w_ptr_succ=1, r_ptr_succ=1.
- Fill with a head pop (B=8, W=3):
  - Write 10,20,30,40 on four cycles -> r_data=10, empty=0, full=0, w_ptr_succ=5.
  - One read -> r_data=20, r_ptr_succ=2.
- Wrap to full: write 50,60,70,80,90 -> full=1 after 90 (8 words stored, w_ptr wrapped to 1 = r_ptr), w_ptr_succ=2.
  - A further write of 99 is ignored: contents unchanged, full stays 1.
- Drain across wrap: 8 consecutive reads -> r_data sequence 20,30,40,50,60,70,80,90, then empty=1 after the 8th read.
  - An extra read leaves pointers unchanged.
- Simultaneous ops:
  - wr=rd=1 with data 5 when empty -> word stored, empty=0, r_data=5.
  - wr=rd=1 when full -> head popped, new word appended, full stays 1.
- Mid-operation reset: with 3 words stored, pulse reset -> empty=1, full=0, r_data=0, both pointers 0.
